fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the decodeInstruction/operand_lut control path.
- Owns the architectural PC and issues word addresses to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue and presents them to decode through a valid/ready handshake.
- Accepts branch, jump and jump-register redirects from execute, computes the target, and squashes wrong-path fetches.

---
 rtl/fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// imem, buffers responses in a 2-entry queue and applies execute redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          W        = 32
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic [W-1:0] imem_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_instr,
  output logic [W-1:0] out_pc,
  output logic [W-1:0] out_pc4,
  input  logic         redir_branch,
  input  logic         redir_jump,
  input  logic         redir_jr,
  input  logic [W-1:0] redir_pc4,
  input  logic [15:0]  redir_imm,
  input  logic [25:0]  redir_jaddr,
  input  logic [W-1:0] redir_reg
);

  logic [W-1:0]        pc_q, pc_d, req_pc_q, target;
  logic [1:0][W-1:0]   instr_q, fpc_q;
  logic [1:0]          count_q, count_d;
  logic                head_q, head_d, wr_idx;
  logic                pending_q, drop_q;
  logic                redirect, pop, push;
  logic [2:0]          occ;

  assign redirect = redir_branch | redir_jump | redir_jr;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = pending_q & ~drop_q & ~redirect;
  assign wr_idx    = head_q ^ count_q[0];

  // Occupancy the queue will see once the in-flight response lands; issuing
  // only at <=1 guarantees room for every response without stalling imem.
  assign occ       = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
  assign imem_req  = ~reset & ~redirect & (occ <= 3'd1);
  assign imem_addr = pc_q;

  assign out_instr = instr_q[head_q];
  assign out_pc    = fpc_q[head_q];
  assign out_pc4   = fpc_q[head_q] + 32'd4;

  always_comb begin
    target = {redir_pc4[31:2] + {{14{redir_imm[15]}}, redir_imm}, 2'b00};
    if (redir_jr)        target = {redir_reg[31:2], 2'b00};
    else if (redir_jump) target = {redir_pc4[31:28], redir_jaddr, 2'b00};
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    head_d  = head_q ^ pop;
    if (redirect) begin
      pc_d    = target;
      count_d = 2'd0;
      head_d  = 1'b0;
    end else if (imem_req) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      head_q    <= head_d;
      pending_q <= imem_req;
      drop_q    <= redirect & pending_q;
      if (imem_req) req_pc_q <= pc_q;
      if (push) begin
        instr_q[wr_idx] <= imem_data;
        fpc_q[wr_idx]   <= req_pc_q;
      end
    end
  end

endmodule
